// File: rtl/vga_pixel_out_if.sv
// ============================================================================
// Module      : vga_pixel_out_if
// Description : Pixel/raster bundle between the object mux, the VGA output
//               stage and the drawing objects that consume the counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_pixel_out_if;
    logic [7:0]  RGBIn;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [7:0]  frameCount;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        blankN;

    // Output stage side: takes the muxed pixel, drives raster and VGA pins.
    modport master (
        input  RGBIn,
        output pixelX, pixelY, startOfFrame, frameCount,
        output red, green, blue, hsync, vsync, blankN
    );

    // Mux / consumer side.
    modport slave (
        output RGBIn,
        input  pixelX, pixelY, startOfFrame, frameCount,
        input  red, green, blue, hsync, vsync, blankN
    );
endinterface

`default_nettype wire

// File: rtl/vga_pixel_out.sv
// ============================================================================
// Module      : vga_pixel_out
// Description : 640x480@60 raster generator and VGA output stage with
//               sync/blank alignment to the registered RRRGGGBB pixel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_out #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    vga_pixel_out_if.master   vga
);

    localparam logic [10:0] c_H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] c_V_LAST   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] c_H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] c_V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] c_HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    // Delay-line word is {visible, hsync_n, vsync_n}; idle means blanked, syncs released.
    localparam logic [2:0]  c_DLY_IDLE = 3'b011;

    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_sof;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_blue;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank_n;
    logic [2:0]  r_dly [PIPE_DELAY];

    logic        w_frame_end;
    logic [2:0]  w_raw;
    logic [2:0]  w_dly_out;
    logic [2:0]  w_r;
    logic [2:0]  w_g;
    logic [1:0]  w_b;

    assign w_frame_end = (r_x == c_H_LAST) && (r_y == c_V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_x == c_H_LAST) begin
            r_x <= '0;
            r_y <= (r_y == c_V_LAST) ? 11'd0 : r_y + 11'd1;
        end else begin
            r_x <= r_x + 11'd1;
        end
    end

    // Reset leaves the counters at (0,0) with no pulse, so only true wraps count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sof       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_sof <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign w_raw = {
        (r_x < c_H_VIS) && (r_y < c_V_VIS),
        !((r_x >= c_HS_START) && (r_x < c_HS_END)),
        !((r_y >= c_VS_START) && (r_y < c_VS_END))
    };

    generate
        for (genvar i = 0; i < PIPE_DELAY; i++) begin : g_dly
            if (i == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) r_dly[i] <= c_DLY_IDLE;
                    else       r_dly[i] <= w_raw;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (reset) r_dly[i] <= c_DLY_IDLE;
                    else       r_dly[i] <= r_dly[i-1];
                end
            end
        end
    endgenerate

    assign w_dly_out = r_dly[PIPE_DELAY-1];
    assign w_r       = vga.RGBIn[7:5];
    assign w_g       = vga.RGBIn[4:2];
    assign w_b       = vga.RGBIn[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_red     <= w_dly_out[2] ? {w_r, w_r, w_r[2:1]} : 8'd0;
            r_green   <= w_dly_out[2] ? {w_g, w_g, w_g[2:1]} : 8'd0;
            r_blue    <= w_dly_out[2] ? {w_b, w_b, w_b, w_b} : 8'd0;
            r_hsync   <= w_dly_out[1];
            r_vsync   <= w_dly_out[0];
            r_blank_n <= w_dly_out[2];
        end
    end

    assign vga.pixelX       = r_x;
    assign vga.pixelY       = r_y;
    assign vga.startOfFrame = r_sof;
    assign vga.frameCount   = r_frame_cnt;
    assign vga.red          = r_red;
    assign vga.green        = r_green;
    assign vga.blue         = r_blue;
    assign vga.hsync        = r_hsync;
    assign vga.vsync        = r_vsync;
    assign vga.blankN       = r_blank_n;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
// ============================================================================
// Module      : tb_vga_pixel_out
// Description : Self-checking bench for vga_pixel_out on a reduced raster.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_out;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 1, VS = 2, VB = 1;
    localparam int PD = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vga_pixel_out_if vif ();

    vga_pixel_out #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .PIPE_DELAY(PD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vif)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         t     = 0;
    int         mode  = 0;
    int         sof_cnt;
    int         budget;
    logic [7:0] rgb_drv  = 8'h00;
    logic [7:0] last_rgb = 8'h00;

    // 3-bit channel scaled to 0..255 by rounding v*255/7.
    function automatic logic [7:0] scale3(input int v);
        return 8'((v * 510 + 7) / 14);
    endfunction

    function automatic bit vis_at(input int k);
        return (k >= 0) && ((k % HT) < HV) && (((k / HT) % VT) < VV);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    task automatic check_all();
        int   k, x, y;
        logic vis, hs, vs;
        k   = t - PD - 1;
        vis = 1'b0;
        hs  = 1'b1;
        vs  = 1'b1;
        if (k >= 0) begin
            x   = k % HT;
            y   = (k / HT) % VT;
            vis = (x < HV) && (y < VV);
            hs  = !((x >= HV + HF) && (x < HV + HF + HS));
            vs  = !((y >= VV + VF) && (y < VV + VF + VS));
        end
        chk("pixelX", 32'(vif.pixelX), 32'(t % HT));
        chk("pixelY", 32'(vif.pixelY), 32'((t / HT) % VT));
        chk("sof", 32'(vif.startOfFrame), 32'((t > 0) && (t % FT == 0)));
        chk("frameCount", 32'(vif.frameCount), 32'((t / FT) % 256));
        chk("hsync", 32'(vif.hsync), 32'(hs));
        chk("vsync", 32'(vif.vsync), 32'(vs));
        chk("blankN", 32'(vif.blankN), 32'(vis));
        chk("red", 32'(vif.red), vis ? 32'(scale3(int'(last_rgb[7:5]))) : 32'd0);
        chk("green", 32'(vif.green), vis ? 32'(scale3(int'(last_rgb[4:2]))) : 32'd0);
        chk("blue", 32'(vif.blue), vis ? 32'(int'(last_rgb[1:0]) * 85) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        last_rgb = rgb_drv;
        @(negedge clk);
        check_all();
        if (vif.startOfFrame === 1'b1) sof_cnt++;
        case (mode)
            0:       rgb_drv = 8'($urandom);
            1:       rgb_drv = 8'hFF;
            2:       rgb_drv = 8'b101_010_01;
            default: rgb_drv = 8'(((t - 1) % HT) * 37 + 5);
        endcase
        vif.RGBIn = rgb_drv;
    endtask

    // Called at a negedge; the next edge samples reset high.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        t = 0;
        chk("noX", 32'($isunknown({vif.pixelX, vif.pixelY, vif.startOfFrame, vif.frameCount,
                                   vif.red, vif.green, vif.blue, vif.hsync, vif.vsync,
                                   vif.blankN})), 32'd0);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        vif.RGBIn = rgb_drv;
        do_reset(3);

        // Random pixels; exactly one frame pulse in the first frame period.
        mode    = 0;
        sof_cnt = 0;
        repeat (FT) step();
        chk("sof_once", 32'(sof_cnt), 32'd1);
        chk("fc_one", 32'(vif.frameCount), 32'd1);
        repeat (FT) step();

        // Saturated white: colour only where blankN is high.
        mode    = 1;
        rgb_drv = 8'hFF;
        repeat (FT) step();

        // Fixed pattern, check the literal expansion at a visible pixel.
        mode    = 2;
        rgb_drv = 8'b101_010_01;
        repeat (3) step();
        budget = 0;
        while (!vis_at(t + 1 - PD - 1) && budget < FT) begin
            step();
            budget++;
        end
        step();
        chk("a9_red", 32'(vif.red), 32'h0B6);
        chk("a9_green", 32'(vif.green), 32'h049);
        chk("a9_blue", 32'(vif.blue), 32'h055);
        chk("a9_blankN", 32'(vif.blankN), 32'd1);

        // RGB as a function of the previous cycle's pixelX.
        mode = 3;
        repeat (FT) step();

        // Reset mid-line while hsync is being driven low.
        mode   = 0;
        budget = 0;
        while (!((t % HT == HV + HF + 2) && ((t / HT) % VT == 3)) && budget < 2 * FT) begin
            step();
            budget++;
        end
        chk("pre_reset_hsync", 32'(vif.hsync), 32'd0);
        do_reset(1);
        chk("rst_hsync", 32'(vif.hsync), 32'd1);
        chk("rst_frameCount", 32'(vif.frameCount), 32'd0);

        // 256 frames: frameCount wraps back to 0.
        repeat (256 * FT) step();
        chk("wrap_fc", 32'(vif.frameCount), 32'd0);
        chk("wrap_sof", 32'(vif.startOfFrame), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
